// File: rtl/csr_counter_array.sv
// Machine counter/timer CSR unit: mcycle, minstret, mhpmcounter/mhpmevent, mcountinhibit and user shadows.
// Build option: define CSR_HPM_EN to implement the NUM_HPM event counters; otherwise their addresses hit and read 0.
module csr_counter_array #(
    parameter int unsigned COUNTER_W  = 64,
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_csr_ex,
    input  logic [11:0]           csr_ofs_ex,
    input  logic [4:0]            csr_uimm_ex,
    input  logic [2:0]            csr_op2_ex,
    input  logic [31:0]           rs1_sel,
    input  logic                  stall,
    input  logic                  retire,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic                  csr_cnt_hit,
    output logic [31:0]           csr_cnt_rd_data
);
    localparam int unsigned HI_W = COUNTER_W - 32;
`ifdef CSR_HPM_EN
    localparam int unsigned EVT_W    = 256;
    localparam logic [31:0] HPM_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
`else
    localparam logic [31:0] HPM_MASK = 32'd0;
`endif
    localparam logic [31:0] INH_MASK = 32'h0000_0005 | HPM_MASK;

    // A counter either takes the CSR write (one half) or its increment, never both.
    function automatic logic [COUNTER_W-1:0] cnt_next(
        input logic [COUNTER_W-1:0] cur,
        input logic                 wr,
        input logic                 hi,
        input logic [31:0]          wd,
        input logic                 inc
    );
        cnt_next = cur;
        if (wr) begin
            if (hi) cnt_next[COUNTER_W-1:32] = wd[HI_W-1:0];
            else    cnt_next[31:0]           = wd;
        end else if (inc) begin
            cnt_next = cur + COUNTER_W'(1);
        end
    endfunction

    logic [4:0] idx;
    logic       hi_half;
    logic       cnt_range;
    logic       is_mcnt;
    logic       is_shadow;
    logic       is_cnt;
    logic       is_inh;
    logic       is_evt;

    // Address decode: counter pages 0xB/0xC share the low/high layout, 0x320-0x33F holds controls.
    always_comb begin
        idx       = csr_ofs_ex[4:0];
        hi_half   = csr_ofs_ex[7];
        cnt_range = (csr_ofs_ex[6:5] == 2'b00) && (idx != 5'd1);
        is_mcnt   = (csr_ofs_ex[11:8] == 4'hB) && cnt_range;
        is_shadow = (csr_ofs_ex[11:8] == 4'hC) && cnt_range;
        is_cnt    = is_mcnt || is_shadow;
        is_inh    = (csr_ofs_ex == 12'h320);
        is_evt    = (csr_ofs_ex[11:5] == 7'h19) && (idx >= 5'd3);
    end

    assign csr_cnt_hit = is_cnt || is_inh || is_evt;

    logic [COUNTER_W-1:0] mcycle_q;
    logic [COUNTER_W-1:0] minstret_q;
    logic [31:0]          inhibit_q;

`ifdef CSR_HPM_EN
    logic [COUNTER_W-1:0] hpm_cnt [NUM_HPM];
    logic [7:0]           hpm_evt [NUM_HPM];
    logic [EVT_W-1:0]     evt_vec;

    // Bit k of evt_vec is event_in[k-1]; selector 0 and out-of-range selectors land on zeros.
    assign evt_vec = EVT_W'({event_in, 1'b0});
`else
    logic unused_evt;
    assign unused_evt = ^event_in;
`endif

    logic [COUNTER_W-1:0] cnt_sel;
    logic [7:0]           evt_sel;

    always_comb begin
        cnt_sel = '0;
        evt_sel = '0;
        if (idx == 5'd0) cnt_sel = mcycle_q;
        if (idx == 5'd2) cnt_sel = minstret_q;
`ifdef CSR_HPM_EN
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (idx == 5'(i + 3)) begin
                cnt_sel = hpm_cnt[i];
                evt_sel = hpm_evt[i];
            end
        end
`endif
    end

    always_comb begin
        csr_cnt_rd_data = '0;
        if (is_cnt) begin
            csr_cnt_rd_data = hi_half ? 32'(cnt_sel[COUNTER_W-1:32]) : cnt_sel[31:0];
        end else if (is_inh) begin
            csr_cnt_rd_data = inhibit_q;
        end else if (is_evt) begin
            csr_cnt_rd_data = 32'(evt_sel);
        end
    end

    logic [31:0] wsrc;
    logic [31:0] wdata;
    logic        we;
    logic        wr_mcycle;
    logic        wr_minstret;

    // Read-modify-write operand; shadows hit but never produce a write strobe.
    always_comb begin
        wsrc = csr_op2_ex[2] ? 32'(csr_uimm_ex) : rs1_sel;
        case (csr_op2_ex[1:0])
            2'b01:   wdata = wsrc;
            2'b10:   wdata = csr_cnt_rd_data | wsrc;
            2'b11:   wdata = csr_cnt_rd_data & ~wsrc;
            default: wdata = csr_cnt_rd_data;
        endcase
        we          = cmd_csr_ex && csr_cnt_hit && !stall && (csr_op2_ex[1:0] != 2'b00) && !is_shadow;
        wr_mcycle   = we && is_mcnt && (idx == 5'd0);
        wr_minstret = we && is_mcnt && (idx == 5'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inhibit_q  <= '0;
        end else begin
            mcycle_q   <= cnt_next(mcycle_q, wr_mcycle, hi_half, wdata, !inhibit_q[0]);
            minstret_q <= cnt_next(minstret_q, wr_minstret, hi_half, wdata, retire && !inhibit_q[2]);
            if (we && is_inh) inhibit_q <= wdata & INH_MASK;
        end
    end

`ifdef CSR_HPM_EN
    for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
        logic [COUNTER_W-1:0] cnt_q;
        logic [7:0]           evt_q;
        logic                 wr_cnt;
        logic                 wr_evt;
        logic                 inc;

        assign wr_cnt     = we && is_mcnt && (idx == 5'(g + 3));
        assign wr_evt     = we && is_evt && (idx == 5'(g + 3));
        assign inc        = evt_vec[evt_q] && !inhibit_q[g + 3];
        assign hpm_cnt[g] = cnt_q;
        assign hpm_evt[g] = evt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                evt_q <= '0;
            end else begin
                cnt_q <= cnt_next(cnt_q, wr_cnt, hi_half, wdata, inc);
                if (wr_evt) evt_q <= wdata[7:0];
            end
        end
    end
`endif

endmodule

// File: doc/csr_counter_array.md
# csr_counter_array

Parametrised machine counter/timer CSR unit: mcycle, minstret and NUM_HPM event-selectable hardware performance counters, each COUNTER_W bits wide, plus mcountinhibit and user read-only shadows. Sits in EX beside the existing CSR register file, sharing its CSR command decode, and contributes its read data whenever its own address decode hits. Counters run every clock; CSR writes are gated by stall.

## Interface
- COUNTER_W, 64, counter width in bits, legal range 33..64; bits above COUNTER_W read 0 and ignore writes
- NUM_HPM, 4, number of mhpmcounter/mhpmevent pairs starting at index 3, legal range 1..29
- NUM_EVENTS, 8, width of event_in, legal range 1..255
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high
- cmd_csr_ex  input  1  CSR instruction in EX
- csr_ofs_ex  input  12  CSR address
- csr_uimm_ex  input  5  immediate operand
- csr_op2_ex  input  3  [2] immediate select; [1:0] 01 rw, 10 set, 11 clear, 00 no write
- rs1_sel  input  32  register operand
- stall  input  1  pipeline stall; blocks CSR writes only
- retire  input  1  one instruction retired this cycle
- event_in  input  NUM_EVENTS  event pulses, one count per asserted cycle
- csr_cnt_hit  output  1  csr_ofs_ex decodes to a register of this block
- csr_cnt_rd_data  output  32  read data, 0 when csr_cnt_hit is 0

## Operation
- Address map: mcycle 0xB00/0xB80(high); minstret 0xB02/0xB82; mhpmcounter(3+i) 0xB03+i/0xB83+i; mhpmevent(3+i) 0x323+i; mcountinhibit 0x320; read-only shadows cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounter(3+i) 0xC03+i/0xC83+i.
- Operand: wdata_src = imm ? zero-extended uimm : rs1_sel. rw: new = src; set: new = old | src; clear: new = old & ~src; old is the current 32-bit read value.
- Write strobe: cmd_csr_ex & csr_cnt_hit & ~stall & op[1:0] != 00 & address not in 0xC00-0xC9F. Shadow writes are silently dropped.
- Low-half write replaces counter[31:0], keeps high bits; high-half write replaces counter[COUNTER_W-1:32], keeps low bits.
- mcountinhibit: bit0 CY, bit2 IR, bit(3+i) HPM i; other bits read 0. An inhibited counter holds its value; it remains writable.
- mhpmevent: stores wdata[7:0]; reads zero-extended. Value k in 1..NUM_EVENTS counts event_in[k-1]; 0 or above NUM_EVENTS counts nothing.
- Increment each clock: mcycle +1 always; minstret +1 when retire; mhpmcounter +1 when selected event is high, each gated by its inhibit bit.
- Write vs increment in the same cycle: the write wins and that counter does not increment (either half).
- Overflow: COUNTER_W-bit wrap to 0, no flag, no trap.
- Reset: all counters, mcountinhibit and mhpmevent to 0; csr_cnt_rd_data follows decode (0 with no hit).

## Timing
- Read path combinational: csr_cnt_rd_data and csr_cnt_hit valid in the same cycle as csr_ofs_ex; value is the pre-edge register (pre-increment).
- Write and increment take effect on the next rising clk edge; a read in the following cycle sees the new value.
- Writes to mcountinhibit/mhpmevent affect counting from the cycle after the write edge.
- rst asserted mid-operation: every register takes its reset value at that edge; rst has priority over writes and increments.
- stall high: writes dropped, increments continue.

## Configuration
- CSR_HPM_EN defined: NUM_HPM counters, events and shadows implemented as above.
- CSR_HPM_EN undefined: no HPM storage; 0xB03-0xB1F, 0xB83-0xB9F, 0x323-0x33F, 0xC03-0xC1F, 0xC83-0xC9F still hit but read 0 and ignore writes; mcountinhibit bits 3+ read 0; event_in unused.

## Test plan
- rst for 1 cycle, release, idle 10 cycles -> read 0xB00 returns 10, 0xB80 returns 0, 0xB02 returns 0.
- csrrw 0xB00 with rs1_sel=0xFFFF_FFFE, 0xB80 with 0xFFFF_FFFF (COUNTER_W=64) -> after 2 more cycles mcycle wraps to 0x0000_0000_0000_0000 and 0xB80 reads 0.
- Set mcountinhibit=0x4, pulse retire 5 cycles -> minstret unchanged; clear to 0, pulse retire 5 cycles -> minstret +5.
- mhpmevent3=2, event_in=8'b0000_0010 for 7 cycles, event_in[0] toggling -> mhpmcounter3 = 7; mhpmevent3=9 (NUM_EVENTS=8) -> counter frozen.
- csrrs 0xB02 with stall=1 -> minstret unchanged by the write and keeps counting retires; csrrw 0xC00 -> mcycle unaffected.
- csrrw 0xB02 = 100 while retire=1 same cycle -> next cycle minstret reads 100, not 101.
